fold_hpc3o_seq: RTL and testbench

Sequencer and accumulator that drives a folded HPC3 masked-AND gadget (share-serial, control index `s`) from a valid/ready operand interface. It sits directly upstream and downstream of the gadget instance. It latches one pair of sharings, primes the gadget's one-cycle-delayed `inb_prev` operand, and steps `s` through 0..d-1 while pulling one fresh randomness word per step from the PRNG. It XOR-accumulates the gadget's latency-1 outputs into the result sharing.

---
 rtl/fold_hpc3o_seq.sv | 142 ++++++++++++++
 tb/tb_fold_hpc3o_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fold_hpc3o_seq.sv
// fold_hpc3o_seq
//   Sequencer/accumulator wrapped around a folded (share-serial) HPC3 masked
//   AND gadget. Latches one pair of sharings, primes the gadget's delayed
//   inb_prev operand, then steps the share index s = 0..d-1. Each step takes
//   one fresh PRNG word. The gadget's latency-1 outputs are XOR-folded into
//   the result sharing.
//
// Optional feature macro: FOLD_ZEROIZE_EN
//   When defined, the operands and the accumulator are cleared on the out
//   handshake. Idle gadget operands are driven to 0. `out` reads 0 while
//   out_valid is low.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   in_valid/in_ready, ina/inb operand sharings (d bits each)
//   rnd_valid/rnd_ready/rnd_in PRNG word stream (RND_W bits)
//   g_ina/g_inb/g_inb_prev     gadget share operands
//   g_rnd, g_s                 gadget randomness and share index
//   g_out                      gadget output (latency 1)
//   out_valid/out_ready, out   result sharing of a&b
module fold_hpc3o_seq #(
  parameter int d          = 2,
  parameter int SHIDX_BITS = 3,
  parameter int RND_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [d-1:0]          ina,
  input  logic [d-1:0]          inb,
  input  logic                  rnd_valid,
  output logic                  rnd_ready,
  input  logic [RND_W-1:0]      rnd_in,
  output logic [d-1:0]          g_ina,
  output logic [d-1:0]          g_inb,
  output logic [d-1:0]          g_inb_prev,
  output logic [RND_W-1:0]      g_rnd,
  output logic [SHIDX_BITS-1:0] g_s,
  input  logic [d-1:0]          g_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [d-1:0]          out
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRIME, S_RUN, S_DRAIN, S_DONE
  } state_t;

  state_t                state, state_nxt;
  logic [SHIDX_BITS-1:0] step;
  logic [d-1:0]          op_a, op_b, acc;
  logic                  fire, fire_q, last_step, accept, out_hs, share_en;

  assign accept    = (state == S_IDLE) && in_valid;
  assign fire      = (state == S_RUN) && rnd_valid;
  assign last_step = (step == SHIDX_BITS'(d - 1));
  assign out_hs    = (state == S_DONE) && out_ready;

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (in_valid) state_nxt = S_PRIME;
      S_PRIME: state_nxt = S_RUN;
      S_RUN:   if (fire && last_step) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // ---------------- step counter / fire pipeline ----------------
  // step stops at d-1 rather than wrapping. The transition to DRAIN already
  // marks the end of the sequence.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step   <= '0;
      fire_q <= 1'b0;
    end else begin
      fire_q <= fire;
      if (accept)                 step <= '0;
      else if (fire && !last_step) step <= step + 1'b1;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a <= '0;
      op_b <= '0;
      acc  <= '0;
    end else begin
      if (accept) begin
        op_a <= ina;
        op_b <= inb;
        acc  <= '0;
      end else if (fire_q) begin
        // fire_q marks the cycle in which g_out holds a fired step's result.
        acc <= acc ^ g_out;
      end
`ifdef FOLD_ZEROIZE_EN
      if (out_hs) begin
        op_a <= '0;
        op_b <= '0;
        acc  <= '0;
      end
`endif
    end
  end

  // The gadget reads b from one cycle earlier. Loading this register with
  // g_inb every cycle makes it equal op_b after PRIME, including during stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) g_inb_prev <= '0;
    else        g_inb_prev <= g_inb;
  end

`ifdef FOLD_ZEROIZE_EN
  assign share_en = (state == S_PRIME) || (state == S_RUN) || (state == S_DRAIN);
  assign out      = out_valid ? acc : '0;
`else
  assign share_en = 1'b1;
  assign out      = acc;
`endif

  assign g_ina     = share_en ? op_a : '0;
  assign g_inb     = share_en ? op_b : '0;
  assign g_s       = step;
  // A word reaches the gadget only in the cycle it is consumed. Stalled
  // cycles therefore carry no randomness.
  assign g_rnd     = fire ? rnd_in : '0;
  assign rnd_ready = fire;
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule

// File: tb/tb_fold_hpc3o_seq.sv
module tb_fold_hpc3o_seq;
  localparam int D  = 2;
  localparam int SB = 3;
  localparam int RW = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready;
  logic [D-1:0]  ina, inb;
  logic          rnd_valid, rnd_ready;
  logic [RW-1:0] rnd_in;
  logic [D-1:0]  g_ina, g_inb, g_inb_prev, g_out;
  logic [RW-1:0] g_rnd;
  logic [SB-1:0] g_s;
  logic          out_valid, out_ready;
  logic [D-1:0]  out_s;

  int checks   = 0;
  int failures = 0;

  fold_hpc3o_seq #(.d(D), .SHIDX_BITS(SB), .RND_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .ina(ina), .inb(inb),
    .rnd_valid(rnd_valid), .rnd_ready(rnd_ready), .rnd_in(rnd_in),
    .g_ina(g_ina), .g_inb(g_inb), .g_inb_prev(g_inb_prev),
    .g_rnd(g_rnd), .g_s(g_s), .g_out(g_out),
    .out_valid(out_valid), .out_ready(out_ready), .out(out_s)
  );

  always #5 clk = ~clk;

  // Toy folded gadget with latency 1. Step s yields share i = a_i & b_s ^ r0.
  // The mask cancels across the two shares. The XOR over all steps and shares
  // is therefore (^a)&(^b).
  always @(posedge clk) begin
    for (int i = 0; i < D; i++)
      g_out[i] <= (g_s < SB'(D)) ? ((g_ina[i] & g_inb[g_s[0]]) ^ g_rnd[0]) : 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", name, got, exp, $time);
    end
  endtask

  // One full operation. The sharings a/b are given, w0/w1 are the PRNG words,
  // and stall is the number of idle rnd cycles after step 0. hold is the
  // number of cycles out_ready stays low in DONE. exp is the plaintext a&b.
  task automatic run_op(input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] w0, input logic [1:0] w1,
                        input int stall, input int hold, input logic exp);
    logic [1:0] words [2];
    logic [1:0] held;
    int k, stalled, lat, bound;
    words[0] = w0; words[1] = w1;
    k = 0; stalled = 0; lat = 0;
    @(negedge clk);
    ina = a; inb = b; in_valid = 1'b1; rnd_valid = 1'b1; out_ready = (hold == 0);
    bound = 0;
    while (!in_ready && bound < 20) begin @(negedge clk); bound++; end
    chk("accept_ready", in_ready, 1'b1);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      rnd_valid = 1'b1;
      if (k == 1 && stalled < stall) begin rnd_valid = 1'b0; stalled++; end
      rnd_in = (k < 2) ? words[k] : 2'b00;
      #1;
      if (out_valid) begin lat = i; break; end
      chk("g_ina", g_ina, a);
      chk("g_inb", g_inb, b);
      if (i >= 2) chk("g_inb_prev", g_inb_prev, b);
      if (i == 1 || k >= 2) chk("rnd_ready_idle", rnd_ready, 1'b0);
      if (rnd_ready) begin
        chk("g_s", g_s, k);
        chk("g_rnd", g_rnd, words[k]);
        k++;
      end else begin
        chk("g_rnd_zero", g_rnd, 2'b00);
        if (i >= 2 && k == 1) chk("g_s_hold", g_s, 1);
      end
    end
    chk("latency", lat, 5 + stall);
    chk("words_used", k, 2);
    chk("result", ^out_s, exp);
    if (hold > 0) begin
      held = out_s;
      in_valid = 1'b1;
      for (int j = 0; j < hold; j++) begin
        @(negedge clk); #1;
        chk("hold_out", out_s, held);
        chk("hold_valid", out_valid, 1'b1);
        chk("hold_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      in_valid  = 1'b0;
    end
    @(negedge clk); #1;
    chk("post_in_ready", in_ready, 1'b1);
    chk("post_out_valid", out_valid, 1'b0);
`ifdef FOLD_ZEROIZE_EN
    chk("zero_g_ina", g_ina, 2'b00);
    chk("zero_g_inb", g_inb, 2'b00);
    chk("zero_out", out_s, 2'b00);
`else
    chk("keep_g_ina", g_ina, a);
    chk("keep_g_inb", g_inb, b);
    chk("keep_out", ^out_s, exp);
`endif
  endtask

  typedef struct {
    logic [1:0] a, b, w0, w1;
    int stall, hold;
    logic exp;
  } vec_t;

  vec_t tv [8];

  initial begin
    // Plaintext a = ^a_sharing, b = ^b_sharing, and exp = a&b by hand.
    tv[0] = '{2'b01, 2'b10, 2'b01, 2'b10, 0, 0, 1'b1};
    tv[1] = '{2'b11, 2'b01, 2'b11, 2'b00, 0, 0, 1'b0};
    tv[2] = '{2'b10, 2'b11, 2'b10, 2'b01, 0, 0, 1'b0};
    tv[3] = '{2'b00, 2'b00, 2'b01, 2'b11, 0, 0, 1'b0};
    tv[4] = '{2'b10, 2'b01, 2'b11, 2'b11, 0, 0, 1'b1};
    tv[5] = '{2'b11, 2'b11, 2'b00, 2'b10, 0, 0, 1'b0};
    tv[6] = '{2'b01, 2'b01, 2'b10, 2'b11, 3, 0, 1'b1};
    tv[7] = '{2'b10, 2'b10, 2'b01, 2'b01, 0, 4, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; ina = '0; inb = '0;
    rnd_valid = 1'b1; rnd_in = 2'b11; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_rnd_ready", rnd_ready, 1'b0);
    chk("rst_g_s", g_s, 0);
    chk("rst_g_rnd", g_rnd, 2'b00);
    chk("rst_g_inb_prev", g_inb_prev, 2'b00);
    chk("rst_out", out_s, 2'b00);
    @(negedge clk); rst_n = 1'b1;

    for (int v = 0; v < 8; v++)
      run_op(tv[v].a, tv[v].b, tv[v].w0, tv[v].w1, tv[v].stall, tv[v].hold, tv[v].exp);

    // Reset in the middle of RUN, after step 0 has consumed its word.
    @(negedge clk);
    ina = 2'b01; inb = 2'b01; in_valid = 1'b1; rnd_valid = 1'b1; rnd_in = 2'b10;
    @(negedge clk); in_valid = 1'b0;   // PRIME
    @(negedge clk);                    // step 0 fires
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_g_s", g_s, 0);
    chk("mid_rst_rnd_ready", rnd_ready, 1'b0);
    chk("mid_rst_g_rnd", g_rnd, 2'b00);
    chk("mid_rst_out", out_s, 2'b00);
    @(negedge clk); rst_n = 1'b1;
    run_op(2'b10, 2'b01, 2'b01, 2'b11, 0, 0, 1'b1);

    // All four plaintext combinations, with random sharings and words.
    for (int c = 0; c < 4; c++) begin
      for (int n = 0; n < 100; n++) begin
        logic pa, pb, sa, sb;
        logic [1:0] w0, w1;
        pa = c[0]; pb = c[1];
        sa = 1'($urandom); sb = 1'($urandom);
        w0 = 2'($urandom); w1 = 2'($urandom);
        run_op({sa ^ pa, sa}, {sb ^ pb, sb}, w0, w1, 0, 0, pa & pb);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
